// File: rtl/fpu_pkg.sv
// Shared binary32 constants, unpacked-operand type and unpack helper for the FPU adder.
package fpu_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int GRS_W   = 3;
  localparam int SIG_W   = MAN_W + 1;
  localparam int ALN_W   = SIG_W + GRS_W;
  localparam int SHAMT_W = 5;

  localparam logic [EXP_W-1:0] EXP_MAX   = 8'd255;
  localparam logic [EXP_W:0]   SHAMT_MAX = 9'd27;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] man24;
  } unpacked_t;

  // Denormals take exponent 1 and a zero hidden bit so they align like the smallest normal.
  function automatic unpacked_t unpack_op(input logic [31:0] f);
    unpacked_t u;
    u.sign = f[31];
    if (f[MAN_W +: EXP_W] == '0) begin
      u.exp   = 8'd1;
      u.man24 = {1'b0, f[MAN_W-1:0]};
    end else begin
      u.exp   = f[MAN_W +: EXP_W];
      u.man24 = {1'b1, f[MAN_W-1:0]};
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_add_align_if.sv
// Handshake and result bundle between the operand source, the align stage and the significand adder.
interface fp_add_align_if;
  import fpu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      x;
  logic [31:0]      y;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic             Sx;
  logic             Sy;
  logic             EOP;
  logic             zero_d;
  logic             sign_d;
  logic             cmp;
  logic [EXP_W-1:0] e_big;
  logic [ALN_W-1:0] m_big;
  logic [ALN_W-1:0] m_small;
  logic             special;

  modport master (
    output in_valid, x, y, op, out_ready,
    input  in_ready, out_valid, Sx, Sy, EOP, zero_d, sign_d, cmp,
           e_big, m_big, m_small, special
  );

  modport slave (
    input  in_valid, x, y, op, out_ready,
    output in_ready, out_valid, Sx, Sy, EOP, zero_d, sign_d, cmp,
           e_big, m_big, m_small, special
  );

endinterface

// File: rtl/fp_rshift_sticky.sv
// Log-depth right shifter with the shift amount saturated at the aligned width.
// FPU_ALIGN_STICKY_EN folds every shifted-out bit into result bit 0; otherwise they are dropped.
module fp_rshift_sticky
  import fpu_pkg::*;
(
  input  logic [ALN_W-1:0] data_in,
  input  logic [EXP_W:0]   shamt,
  output logic [ALN_W-1:0] data_out
);

  localparam int STAGES = SHAMT_W;

  logic [SHAMT_W-1:0] shamt_sat;
  logic [ALN_W-1:0]   stage_data [0:STAGES];

  // Anything at or beyond 27 clears the whole word, so 27 is a safe ceiling.
  assign shamt_sat = (shamt > SHAMT_MAX) ? SHAMT_MAX[SHAMT_W-1:0] : shamt[SHAMT_W-1:0];

  assign stage_data[0] = data_in;

`ifdef FPU_ALIGN_STICKY_EN
  logic [STAGES:0] sticky;
  assign sticky[0] = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage_data[gi+1] = shamt_sat[gi] ? (stage_data[gi] >> SH) : stage_data[gi];
`ifdef FPU_ALIGN_STICKY_EN
      assign sticky[gi+1] = sticky[gi] | (shamt_sat[gi] & (|stage_data[gi][SH-1:0]));
`endif
    end
  endgenerate

`ifdef FPU_ALIGN_STICKY_EN
  assign data_out = {stage_data[STAGES][ALN_W-1:1], stage_data[STAGES][0] | sticky[STAGES]};
`else
  assign data_out = stage_data[STAGES];
`endif

endmodule

// File: rtl/fp_add_align.sv
// Two-stage unpack/exponent-compare and swap/align front end of the binary32 adder.
// Sticky collection in the aligner is controlled by FPU_ALIGN_STICKY_EN.
module fp_add_align
  import fpu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fp_add_align_if.slave bus
);

  // ---------------- stage 1: unpack and compare ----------------
  unpacked_t ux;
  unpacked_t uy;

  assign ux = unpack_op(bus.x);
  assign uy = unpack_op(bus.y);

  logic             s1_valid_reg;
  logic             s1_sx_reg;
  logic             s1_sy_reg;
  logic             s1_eop_reg;
  logic [SIG_W-1:0] s1_mx_reg;
  logic [SIG_W-1:0] s1_my_reg;
  logic [EXP_W-1:0] s1_ex_reg;
  logic [EXP_W-1:0] s1_ey_reg;
  logic [EXP_W:0]   s1_d_reg;
  logic             s1_zero_d_reg;
  logic             s1_sign_d_reg;
  logic             s1_cmp_reg;
  logic             s1_special_reg;

  logic s2_valid_reg;
  logic s2_ready;
  logic s1_ready;
  logic s1_load;
  logic s2_load;

  assign s2_ready     = !s2_valid_reg | bus.out_ready;
  assign s1_ready     = !s1_valid_reg | s2_ready;
  assign s1_load      = bus.in_valid & s1_ready;
  assign s2_load      = s1_valid_reg & s2_ready;
  assign bus.in_ready = s1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_sx_reg      <= 1'b0;
      s1_sy_reg      <= 1'b0;
      s1_eop_reg     <= 1'b0;
      s1_mx_reg      <= '0;
      s1_my_reg      <= '0;
      s1_ex_reg      <= '0;
      s1_ey_reg      <= '0;
      s1_d_reg       <= '0;
      s1_zero_d_reg  <= 1'b0;
      s1_sign_d_reg  <= 1'b0;
      s1_cmp_reg     <= 1'b0;
      s1_special_reg <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid_reg <= bus.in_valid;
      end
      if (s1_load) begin
        s1_sx_reg      <= ux.sign;
        s1_sy_reg      <= uy.sign;
        s1_eop_reg     <= ux.sign ^ uy.sign ^ bus.op;
        s1_mx_reg      <= ux.man24;
        s1_my_reg      <= uy.man24;
        s1_ex_reg      <= ux.exp;
        s1_ey_reg      <= uy.exp;
        s1_d_reg       <= {1'b0, ux.exp} - {1'b0, uy.exp};
        s1_zero_d_reg  <= (ux.exp == uy.exp);
        s1_sign_d_reg  <= (uy.exp > ux.exp);
        s1_cmp_reg     <= (uy.man24 > ux.man24);
        s1_special_reg <= (ux.exp == EXP_MAX) | (uy.exp == EXP_MAX);
      end
    end
  end

  // ---------------- stage 2: swap and align ----------------
  // Equal exponents keep x on the big side; the significand compare is left to the sign logic.
  logic             swap;
  logic [SIG_W-1:0] sig_big;
  logic [SIG_W-1:0] sig_small;
  logic [EXP_W-1:0] e_big_next;
  logic [EXP_W:0]   d_abs;
  logic [ALN_W-1:0] m_big_next;
  logic [ALN_W-1:0] m_small_next;

  assign swap       = s1_sign_d_reg;
  assign sig_big    = swap ? s1_my_reg : s1_mx_reg;
  assign sig_small  = swap ? s1_mx_reg : s1_my_reg;
  assign e_big_next = swap ? s1_ey_reg : s1_ex_reg;
  assign d_abs      = s1_d_reg[EXP_W] ? -s1_d_reg : s1_d_reg;
  assign m_big_next = {sig_big, {GRS_W{1'b0}}};

  fp_rshift_sticky u_rshift (
    .data_in  ({sig_small, {GRS_W{1'b0}}}),
    .shamt    (d_abs),
    .data_out (m_small_next)
  );

  logic             s2_sx_reg;
  logic             s2_sy_reg;
  logic             s2_eop_reg;
  logic             s2_zero_d_reg;
  logic             s2_sign_d_reg;
  logic             s2_cmp_reg;
  logic [EXP_W-1:0] s2_e_big_reg;
  logic [ALN_W-1:0] s2_m_big_reg;
  logic [ALN_W-1:0] s2_m_small_reg;
  logic             s2_special_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg   <= 1'b0;
      s2_sx_reg      <= 1'b0;
      s2_sy_reg      <= 1'b0;
      s2_eop_reg     <= 1'b0;
      s2_zero_d_reg  <= 1'b0;
      s2_sign_d_reg  <= 1'b0;
      s2_cmp_reg     <= 1'b0;
      s2_e_big_reg   <= '0;
      s2_m_big_reg   <= '0;
      s2_m_small_reg <= '0;
      s2_special_reg <= 1'b0;
    end else begin
      if (s2_ready) begin
        s2_valid_reg <= s1_valid_reg;
      end
      // Data only moves with a real op, so a stalled result never changes under the consumer.
      if (s2_load) begin
        s2_sx_reg      <= s1_sx_reg;
        s2_sy_reg      <= s1_sy_reg;
        s2_eop_reg     <= s1_eop_reg;
        s2_zero_d_reg  <= s1_zero_d_reg;
        s2_sign_d_reg  <= s1_sign_d_reg;
        s2_cmp_reg     <= s1_cmp_reg;
        s2_e_big_reg   <= e_big_next;
        s2_m_big_reg   <= m_big_next;
        s2_m_small_reg <= m_small_next;
        s2_special_reg <= s1_special_reg;
      end
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.Sx        = s2_sx_reg;
  assign bus.Sy        = s2_sy_reg;
  assign bus.EOP       = s2_eop_reg;
  assign bus.zero_d    = s2_zero_d_reg;
  assign bus.sign_d    = s2_sign_d_reg;
  assign bus.cmp       = s2_cmp_reg;
  assign bus.e_big     = s2_e_big_reg;
  assign bus.m_big     = s2_m_big_reg;
  assign bus.m_small   = s2_m_small_reg;
  assign bus.special   = s2_special_reg;

endmodule
